pixel_write_arbiter: RTL and testbench
======================================

Name: pixel_write_arbiter

Overview:
Shares the single VGA adapter pixel-write port among NREQ drawing engines, for example the screen-clear sweep, the Bresenham line engine, and later fill engines. A requester holds the port for a whole burst, i.e. one primitive. Selection between requesters is round-robin. The block clips pixels to the visible area, revokes grants from stalled owners by timeout, and keeps status counters. It sits between the drawing FSMs and the VGA adapter.

Parameters:
NREQ, 2, number of requesters (2..4).
X_W, 9, pixel x width.
Y_W, 9, pixel y width.
C_W, 3, colour width.
H_MAX, 160, first illegal x value; pixels with x >= H_MAX are clipped.
V_MAX, 120, first illegal y value; pixels with y >= V_MAX are clipped.
TIMEOUT, 1023, number of consecutive owner cycles without pix_valid before the grant is revoked.

Ports:
clk  in  1  single clock.
reset  in  1  asynchronous, active-low reset.
req  in  NREQ  per-requester bus request; held high for the whole burst.
pix_valid  in  NREQ  per-requester pixel strobe.
last  in  NREQ  final pixel of the burst; qualified by pix_valid.
pix_x  in  NREQ*X_W  packed x coordinates; requester i occupies [i*X_W +: X_W].
pix_y  in  NREQ*Y_W  packed y coordinates, same packing.
pix_color  in  NREQ*C_W  packed colours, same packing.
clr_status  in  1  synchronous clear of drop_count and timeout_flag.
gnt  out  NREQ  one-hot grant, registered.
busy  out  1  high while a grant is held.
owner_id  out  2  index of the current or most recent owner.
vga_x  out  X_W  registered pixel x to the VGA adapter.
vga_y  out  Y_W  registered pixel y to the VGA adapter.
vga_color  out  C_W  registered pixel colour to the VGA adapter.
vga_write  out  1  registered write enable to the VGA adapter.
drop_count  out  16  number of clipped pixels; saturates at 16'hFFFF.
timeout_flag  out  1  sticky; set when a grant is revoked by timeout.

Behaviour:
- Reset (reset low, asynchronous): state=IDLE; gnt=0; busy=0; owner_id=NREQ-1, so requester 0 wins first; vga_x/vga_y/vga_color=0; vga_write=0; drop_count=0; timeout_flag=0; idle timer=0.
- State machine, IDLE → OWN → IDLE:
  - IDLE: gnt=0. If any req bit is high, pick the first requester with req high, searching from owner_id+1 modulo NREQ.
  - The search result is registered: on the next cycle state=OWN, gnt is one-hot on the winner, busy=1 and owner_id=winner.
  - Grant latency is therefore 1 cycle from req to gnt.
- OWN, per cycle:
  - Only the owner's req, pix_valid, last, pix_x, pix_y and pix_color are observed. Signals from other requesters are ignored; their pixels are not buffered.
  - pix_valid[owner] high with the pixel in bounds: the next cycle has vga_write=1 and vga_x/vga_y/vga_color equal to the sampled pixel.
  - pix_valid[owner] high with the pixel out of bounds: vga_write=0 on the next cycle, and drop_count increments.
  - When vga_write is 0, vga_x/vga_y/vga_color hold their last values.
  - Pixel latency is exactly 1 cycle. Throughput is 1 pixel per cycle, with no backpressure.
- Idle timer: cleared on every owner pix_valid; otherwise it increments while in OWN.
- Exit from OWN to IDLE happens on the first of the following, and gnt drops on the next cycle:
  - (a) pix_valid & last: that pixel is still processed normally;
  - (b) req[owner] falls: a pix_valid sampled in that same cycle is still processed;
  - (c) the idle timer reaches TIMEOUT: timeout_flag is set.
- Simultaneous exit conditions: (a) and (c) in the same cycle is impossible because pix_valid clears the timer. (a) and (b) together count as a normal release.
- After release there is at least one IDLE cycle before the next grant, so there is no back-to-back owner overlap. owner_id keeps the last owner, which sets the round-robin pointer.
- A requester that still holds req after release competes again, but has lowest priority.
- Status registers:
  - clr_status zeroes drop_count and timeout_flag on the next edge.
  - If clr_status coincides with a new drop or timeout, the clear wins.
  - drop_count saturates at 16'hFFFF and never wraps.
- Reset during a burst takes effect immediately. The requester must re-request; no pixel from that burst is written afterwards.
- Bounds compare is unsigned: a pixel is legal iff x < H_MAX and y < V_MAX.

Decomposition:
- Shared package, gfx_pkg, holds:
  - H_MAX and V_MAX defaults;
  - the X_W, Y_W and C_W widths;
  - the arbiter state enum: IDLE, OWN.
- Sub-module rr_picker (combinational): takes req and the pointer, returns the one-hot winner and its index. It is reused by future shared-resource arbiters.

Test Plan:
1. Single owner. Reset, then req0=1 and a burst of 3 pixels: (0,0,c=1), (5,7,c=2), and (159,119,c=3) with last.
   - gnt0 rises 1 cycle after req0.
   - vga_write pulses 3 times, each 1 cycle after its pix_valid, with matching coordinates and colours.
   - gnt0 drops the cycle after last.
2. Round-robin. req0=req1=1 simultaneously after reset; each requester sends a 2-pixel burst ending in last, with req held.
   - Grant order is 0, 1, 0, 1, with one IDLE cycle between grants.
3. Clipping. The owner sends (160,0), (0,120), (159,119).
   - Exactly one vga_write occurs, for (159,119).
   - drop_count=2.
4. Timeout. Use TIMEOUT=8 in the bench. req1 is held with no pix_valid.
   - gnt1 is revoked after 8 idle cycles.
   - timeout_flag=1.
   - clr_status then gives timeout_flag=0 and drop_count=0.
5. Non-owner isolation and reset mid-burst. While requester 0 owns the port, requester 1 drives pix_valid.
   - No vga_write occurs for requester 1's pixels.
   - Asserting reset mid-burst zeroes gnt, vga_write and busy immediately.
6. Release by req drop. The owner drops req with pix_valid high and last low.
   - That pixel is still written.
   - gnt drops on the next cycle.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared graphics-path definitions: default screen geometry, pixel field widths
// and the pixel-port arbiter state encoding.
package gfx_pkg;

    localparam int unsigned X_W_DEF   = 9;
    localparam int unsigned Y_W_DEF   = 9;
    localparam int unsigned C_W_DEF   = 3;
    localparam int unsigned H_MAX_DEF = 160;
    localparam int unsigned V_MAX_DEF = 120;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin picker: first set req bit searching upward from ptr+1,
// wrapping modulo N. Returns one-hot winner, its index and whether any bit was set.
module rr_picker #(
    parameter int N = 2
) (
    input  logic [N-1:0] req,
    input  logic [1:0]   ptr,
    output logic [N-1:0] win,
    output logic [1:0]   win_idx,
    output logic         found
);

    always_comb begin
        win     = '0;
        win_idx = ptr;
        found   = 1'b0;
        // Outer loop walks priority order, inner loop keeps every bit select constant.
        for (int k = 0; k < N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!found && req[j] && (((int'(ptr) + 1 + k) % N) == j)) begin
                    found      = 1'b1;
                    win[j]     = 1'b1;
                    win_idx    = 2'(j);
                end
            end
        end
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Shares the VGA pixel-write port among NREQ drawing engines: round-robin burst
// ownership, screen clipping, stall timeout and status counters.
//
//   state | meaning
//   IDLE  | no owner; pick next requester round-robin from owner_id+1
//   OWN   | one requester holds the port and streams pixels until release
module pixel_write_arbiter
    import gfx_pkg::*;
#(
    parameter int          NREQ    = 2,
    parameter int          X_W     = X_W_DEF,
    parameter int          Y_W     = Y_W_DEF,
    parameter int          C_W     = C_W_DEF,
    parameter int unsigned H_MAX   = H_MAX_DEF,
    parameter int unsigned V_MAX   = V_MAX_DEF,
    parameter int unsigned TIMEOUT = 1023
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NREQ-1:0]     req,
    input  logic [NREQ-1:0]     pix_valid,
    input  logic [NREQ-1:0]     last,
    input  logic [NREQ*X_W-1:0] pix_x,
    input  logic [NREQ*Y_W-1:0] pix_y,
    input  logic [NREQ*C_W-1:0] pix_color,
    input  logic                clr_status,
    output logic [NREQ-1:0]     gnt,
    output logic                busy,
    output logic [1:0]          owner_id,
    output logic [X_W-1:0]      vga_x,
    output logic [Y_W-1:0]      vga_y,
    output logic [C_W-1:0]      vga_color,
    output logic                vga_write,
    output logic [15:0]         drop_count,
    output logic                timeout_flag
);

    localparam int TMR_W = $clog2(TIMEOUT + 1);

    arb_state_e       state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [1:0]       owner_q, owner_d;
    logic [X_W-1:0]   vga_x_q, vga_x_d;
    logic [Y_W-1:0]   vga_y_q, vga_y_d;
    logic [C_W-1:0]   vga_color_q, vga_color_d;
    logic             vga_write_q, vga_write_d;
    logic [15:0]      drop_q, drop_d;
    logic             tflag_q, tflag_d;
    logic [TMR_W-1:0] timer_q, timer_d;

    logic [NREQ-1:0]  pick_win;
    logic [1:0]       pick_idx;
    logic             pick_found;

    logic             o_req, o_valid, o_last;
    logic [X_W-1:0]   o_x;
    logic [Y_W-1:0]   o_y;
    logic [C_W-1:0]   o_c;
    logic             in_bounds, drop_evt, tout_evt;

    rr_picker #(.N(NREQ)) u_picker (
        .req     (req),
        .ptr     (owner_q),
        .win     (pick_win),
        .win_idx (pick_idx),
        .found   (pick_found)
    );

    // The one-hot grant doubles as the owner select; other requesters are invisible.
    always_comb begin
        o_req   = 1'b0;
        o_valid = 1'b0;
        o_last  = 1'b0;
        o_x     = '0;
        o_y     = '0;
        o_c     = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                o_req   = req[i];
                o_valid = pix_valid[i];
                o_last  = last[i];
                o_x     = pix_x[i*X_W +: X_W];
                o_y     = pix_y[i*Y_W +: Y_W];
                o_c     = pix_color[i*C_W +: C_W];
            end
        end
    end

    assign in_bounds = (32'(o_x) < H_MAX) && (32'(o_y) < V_MAX);

    always_comb begin
        state_d     = state_q;
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        vga_x_d     = vga_x_q;
        vga_y_d     = vga_y_q;
        vga_color_d = vga_color_q;
        vga_write_d = 1'b0;
        drop_d      = drop_q;
        tflag_d     = tflag_q;
        timer_d     = timer_q;
        drop_evt    = 1'b0;
        tout_evt    = 1'b0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (pick_found) begin
                    state_d = OWN;
                    gnt_d   = pick_win;
                    owner_d = pick_idx;
                end
            end
            OWN: begin
                if (o_valid) begin
                    timer_d = '0;
                    if (in_bounds) begin
                        vga_write_d = 1'b1;
                        vga_x_d     = o_x;
                        vga_y_d     = o_y;
                        vga_color_d = o_c;
                    end else begin
                        drop_evt = 1'b1;
                    end
                end else begin
                    timer_d = timer_q + TMR_W'(1);
                end
                // A falling req on the terminal idle cycle is a normal release, not a revoke.
                tout_evt = o_req && !o_valid && (timer_q == TMR_W'(TIMEOUT - 1));
                if ((o_valid && o_last) || !o_req || tout_evt) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                gnt_d   = '0;
            end
        endcase

        if (clr_status) begin
            drop_d  = '0;
            tflag_d = 1'b0;
        end else begin
            if (drop_evt && (drop_q != 16'hFFFF)) drop_d = drop_q + 16'd1;
            if (tout_evt) tflag_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            gnt_q       <= '0;
            owner_q     <= 2'(NREQ - 1);
            vga_x_q     <= '0;
            vga_y_q     <= '0;
            vga_color_q <= '0;
            vga_write_q <= 1'b0;
            drop_q      <= '0;
            tflag_q     <= 1'b0;
            timer_q     <= '0;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            vga_x_q     <= vga_x_d;
            vga_y_q     <= vga_y_d;
            vga_color_q <= vga_color_d;
            vga_write_q <= vga_write_d;
            drop_q      <= drop_d;
            tflag_q     <= tflag_d;
            timer_q     <= timer_d;
        end
    end

    assign gnt          = gnt_q;
    assign busy         = (state_q == OWN);
    assign owner_id     = owner_q;
    assign vga_x        = vga_x_q;
    assign vga_y        = vga_y_q;
    assign vga_color    = vga_color_q;
    assign vga_write    = vga_write_q;
    assign drop_count   = drop_q;
    assign timeout_flag = tflag_q;

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench for pixel_write_arbiter: directed scenarios plus random
// traffic, all checked against a behavioural burst-ownership model.
module tb_pixel_write_arbiter;

    localparam int N  = 2;
    localparam int XW = 9;
    localparam int YW = 9;
    localparam int CW = 3;
    localparam int TO = 8;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N-1:0]    req = '0;
    logic [N-1:0]    pix_valid = '0;
    logic [N-1:0]    last = '0;
    logic [N*XW-1:0] pix_x = '0;
    logic [N*YW-1:0] pix_y = '0;
    logic [N*CW-1:0] pix_color = '0;
    logic            clr_status = 1'b0;
    logic [N-1:0]    gnt;
    logic            busy;
    logic [1:0]      owner_id;
    logic [XW-1:0]   vga_x;
    logic [YW-1:0]   vga_y;
    logic [CW-1:0]   vga_color;
    logic            vga_write;
    logic [15:0]     drop_count;
    logic            timeout_flag;

    pixel_write_arbiter #(
        .NREQ(N), .X_W(XW), .Y_W(YW), .C_W(CW),
        .H_MAX(160), .V_MAX(120), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .pix_valid(pix_valid), .last(last),
        .pix_x(pix_x), .pix_y(pix_y), .pix_color(pix_color), .clr_status(clr_status),
        .gnt(gnt), .busy(busy), .owner_id(owner_id), .vga_x(vga_x), .vga_y(vga_y),
        .vga_color(vga_color), .vga_write(vga_write), .drop_count(drop_count),
        .timeout_flag(timeout_flag)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int wr_count = 0;

    // Reference model: who owns the port, the round-robin pointer, idle-cycle count,
    // and the expected registered outputs.
    int m_own, m_ptr, m_idle, m_vx, m_vy, m_vc, m_vw, m_drop, m_tf;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_own = -1; m_ptr = N - 1; m_idle = 0;
        m_vx = 0; m_vy = 0; m_vc = 0; m_vw = 0; m_drop = 0; m_tf = 0;
    endtask

    function automatic void model_step();
        int  o, x, y, c, cand;
        bit  v, rel, tout, dropped;
        tout = 0; dropped = 0;
        m_vw = 0;
        if (m_own < 0) begin
            for (int k = 1; k <= N; k++) begin
                cand = (m_ptr + k) % N;
                if (m_own < 0 && req[cand]) begin
                    m_own = cand; m_ptr = cand; m_idle = 0;
                end
            end
        end else begin
            o = m_own;
            v = pix_valid[o];
            x = int'(pix_x[o*XW +: XW]);
            y = int'(pix_y[o*YW +: YW]);
            c = int'(pix_color[o*CW +: CW]);
            if (v) begin
                m_idle = 0;
                if (x < 160 && y < 120) begin
                    m_vw = 1; m_vx = x; m_vy = y; m_vc = c;
                end else begin
                    dropped = 1;
                end
            end else begin
                m_idle++;
                tout = req[o] && (m_idle == TO);
            end
            rel = (v && last[o]) || !req[o] || tout;
            if (rel) m_own = -1;
        end
        if (clr_status) begin
            m_drop = 0; m_tf = 0;
        end else begin
            if (dropped && m_drop < 65535) m_drop++;
            if (tout) m_tf = 1;
        end
    endfunction

    task automatic compare_all();
        chk("gnt", 32'(gnt), (m_own < 0) ? 32'd0 : 32'(1 << m_own));
        chk("busy", 32'(busy), (m_own < 0) ? 32'd0 : 32'd1);
        chk("owner_id", 32'(owner_id), 32'(m_ptr));
        chk("vga_write", 32'(vga_write), 32'(m_vw));
        chk("vga_x", 32'(vga_x), 32'(m_vx));
        chk("vga_y", 32'(vga_y), 32'(m_vy));
        chk("vga_color", 32'(vga_color), 32'(m_vc));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("timeout_flag", 32'(timeout_flag), 32'(m_tf));
        if (vga_write) wr_count++;
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic drive(input int i, input bit r, input bit v, input bit l,
                         input int x, input int y, input int c);
        req[i]                = r;
        pix_valid[i]          = v;
        last[i]               = l;
        pix_x[i*XW +: XW]     = XW'(x);
        pix_y[i*YW +: YW]     = YW'(y);
        pix_color[i*CW +: CW] = CW'(c);
    endtask

    task automatic clear_inputs();
        req = '0; pix_valid = '0; last = '0;
        pix_x = '0; pix_y = '0; pix_color = '0; clr_status = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_vga_write", 32'(vga_write), 32'd0);
        clear_inputs();
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        compare_all();
        chk("rst_owner_id", 32'(owner_id), 32'(N - 1));
    endtask

    function automatic int gnt_idx();
        if (gnt == 2'b01) return 0;
        if (gnt == 2'b10) return 1;
        return 99;
    endfunction

    initial begin
        int cnt, w0, vprob;
        model_reset();
        do_reset();

        // Single owner, three-pixel burst.
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        chk("t1_gnt_latency", 32'(gnt), 32'd1);
        drive(0, 1, 1, 0, 0, 0, 1);
        step();
        chk("t1_px0_write", 32'(vga_write), 32'd1);
        drive(0, 1, 1, 0, 5, 7, 2);
        step();
        chk("t1_px1_xy", 32'({vga_x, vga_y, vga_color}), 32'({9'd5, 9'd7, 3'd2}));
        drive(0, 1, 1, 1, 159, 119, 3);
        step();
        chk("t1_px2_xy", 32'({vga_x, vga_y, vga_color}), 32'({9'd159, 9'd119, 3'd3}));
        chk("t1_gnt_drop", 32'(gnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // Round-robin between two held requesters.
        do_reset();
        req = 2'b11;
        for (int b = 0; b < 4; b++) begin
            cnt = 0;
            step();
            while (gnt == '0 && cnt < 5) begin
                step();
                cnt++;
            end
            chk("t2_order", 32'(gnt_idx()), 32'(b % 2));
            if (gnt_idx() < N) begin
                w0 = gnt_idx();
                drive(w0, 1, 1, 0, 10 + b, 20 + b, b);
                step();
                drive(w0, 1, 1, 1, 11 + b, 21 + b, b + 1);
                step();
                drive(w0, 1, 0, 0, 0, 0, 0);
                chk("t2_idle_gap", 32'(gnt), 32'd0);
            end
        end
        req = '0;
        step();

        // Clipping.
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        wr_count = 0;
        drive(0, 1, 1, 0, 160, 0, 1);
        step();
        drive(0, 1, 1, 0, 0, 120, 2);
        step();
        drive(0, 1, 1, 1, 159, 119, 4);
        step();
        drive(0, 0, 0, 0, 0, 0, 0);
        step();
        chk("t3_writes", 32'(wr_count), 32'd1);
        chk("t3_drops", 32'(drop_count), 32'd2);
        chk("t3_last_x", 32'(vga_x), 32'd159);

        // Timeout on a silent owner, then status clear.
        drive(1, 1, 0, 0, 0, 0, 0);
        step();
        chk("t4_gnt1", 32'(gnt), 32'd2);
        cnt = 1;
        while (gnt == 2'b10 && cnt < 20) begin
            step();
            if (gnt == 2'b10) cnt++;
        end
        chk("t4_hold_cycles", 32'(cnt), 32'(TO));
        chk("t4_tflag", 32'(timeout_flag), 32'd1);
        drive(1, 0, 0, 0, 0, 0, 0);
        clr_status = 1'b1;
        step();
        clr_status = 1'b0;
        chk("t4_clr_tflag", 32'(timeout_flag), 32'd0);
        chk("t4_clr_drop", 32'(drop_count), 32'd0);

        // Non-owner isolation, then reset during a burst.
        do_reset();
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        wr_count = 0;
        drive(1, 1, 1, 0, 10, 10, 6);
        for (int i = 0; i < 3; i++) step();
        chk("t5_no_foreign_write", 32'(wr_count), 32'd0);
        drive(0, 1, 1, 0, 1, 1, 1);
        step();
        chk("t5_owner_write", 32'(vga_write), 32'd1);
        do_reset();

        // Release by req drop with a pixel in the same cycle.
        drive(0, 1, 0, 0, 0, 0, 0);
        step();
        drive(0, 0, 1, 0, 3, 4, 5);
        step();
        chk("t6_write", 32'(vga_write), 32'd1);
        chk("t6_xy", 32'({vga_x, vga_y, vga_color}), 32'({9'd3, 9'd4, 3'd5}));
        chk("t6_gnt_drop", 32'(gnt), 32'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        step();

        // Random traffic with varying pixel density to reach timeouts too.
        for (int blk = 0; blk < 6; blk++) begin
            vprob = (blk % 3 == 0) ? 5 : ((blk % 3 == 1) ? 50 : 90);
            for (int cyc = 0; cyc < 500; cyc++) begin
                for (int i = 0; i < N; i++) begin
                    drive(i,
                          ($urandom_range(0, 7) == 0) ? !req[i] : req[i],
                          ($urandom_range(0, 99) < vprob),
                          ($urandom_range(0, 5) == 0),
                          $urandom_range(0, 200), $urandom_range(0, 150),
                          $urandom_range(0, 7));
                end
                clr_status = ($urandom_range(0, 63) == 0);
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
